// File: rtl/mem_port_master.sv
// mem_port_master: Avalon-MM host turning one command into a burst of RAM word writes or reads
module mem_port_master #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [ADDR_W:0]       cmd_len,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_chipselect,
  output logic                  m_clken,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic [DATA_W-1:0]     m_readdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0] rem;
  logic [RD_LATENCY-1:0] vsr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, outs;
  logic [CW:0] used;
  logic wr_beat, rd_issue, push, pop, rd_fin;
  always_comb begin
    outs = '0;
    for (int i = 0; i < RD_LATENCY; i++) outs = outs + CW'(vsr[i]);
    used = {1'b0, outs} + {1'b0, cnt};
    wr_beat = wr_valid && wr_ready;
    rd_issue = state == RD && rem != '0 && used < (CW+1)'(FIFO_DEPTH);
    push = vsr[RD_LATENCY-1];
    pop = rd_valid && rd_ready;
    rd_fin = state == RD && rem == '0 && vsr == '0 && cnt == CW'(pop);
  end
  assign rd_valid = cnt != '0;
  assign rd_data = mem[rp];
  assign m_address = cur;
  assign m_chipselect = wr_beat || rd_issue;
  assign m_write = wr_beat;
  assign m_writedata = wr_beat ? wr_data : '0;
  assign m_byteenable = {(DATA_W/8){m_chipselect}};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      wr_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      m_clken <= 1'b0;
      cur <= '0;
      rem <= '0;
      vsr <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      m_clken <= 1'b1;
      vsr <= (vsr << 1) | RD_LATENCY'(rd_issue);
      if (push) begin
        mem[wp] <= m_readdata;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (wr_beat || rd_issue) begin
        cur <= cur + ADDR_W'(1);
        rem <= rem - (ADDR_W+1)'(1);
      end
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          cur <= cmd_addr;
          rem <= cmd_len;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
          state <= cmd_len == '0 ? DONE : (cmd_write ? WR : RD);
          wr_ready <= cmd_write && cmd_len != '0;
          done <= cmd_len == '0;
        end else cmd_ready <= 1'b1;
        WR: if (wr_beat && rem == (ADDR_W+1)'(1)) begin
          state <= DONE;
          wr_ready <= 1'b0;
          done <= 1'b1;
        end
        RD: if (rd_fin) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: scoreboard bench for mem_port_master against a behavioural RAM
module tb_mem_port_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [10:0] cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic rd_valid, rd_ready = 1'b0;
  logic busy, done;
  logic [9:0] m_address;
  logic m_chipselect, m_clken, m_write;
  logic [31:0] m_writedata;
  logic [3:0] m_byteenable;
  logic [31:0] m_readdata = '0;
  logic [31:0] ram [1024];
  typedef struct packed {logic [9:0] a; logic [31:0] d;} wr_t;
  wr_t exp_wr[$];
  logic [31:0] exp_rd[$];
  int checks = 0, errors = 0, wr_cnt = 0, rd_iss = 0, done_cnt = 0;

  always #5 clk = ~clk;

  mem_port_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_clken(m_clken),
    .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata)
  );

  always @(posedge clk) begin
    if (m_chipselect && m_write) ram[m_address] <= m_writedata;
    if (m_chipselect && !m_write) m_readdata <= ram[m_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    logic [31:0] r;
    if (!reset) begin
      if (m_chipselect && m_write) begin
        wr_cnt++;
        chk("wr_unexpected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(m_address), 32'(e.a));
          chk("wr_data", m_writedata, e.d);
          chk("wr_byteenable", 32'(m_byteenable), 32'hF);
        end
      end
      if (m_chipselect && !m_write) begin
        rd_iss++;
        chk("rd_byteenable", 32'(m_byteenable), 32'hF);
      end
      if (rd_valid && rd_ready) begin
        chk("rd_unexpected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          r = exp_rd.pop_front();
          chk("rd_data", rd_data, r);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [10:0] l);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic wr_burst(input logic [9:0] a, input int len, input logic [31:0] base);
    logic ok;
    int n;
    for (int i = 0; i < len; i++) exp_wr.push_back('{a + 10'(i), base + 32'(i)});
    send_cmd(1'b1, a, 11'(len));
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1;
      wr_data = base + 32'(i);
      n = 0;
      do begin
        ok = wr_ready;
        @(posedge clk); #1;
        n++;
      end while (!ok && n < 50);
      chk("wr_beat_accept", 32'(ok), 32'd1);
    end
    wr_valid = 1'b0;
    chk("wr_done_latency", 32'(done), 32'd1);
    wait_done("wr_done");
  endtask

  task automatic rd_burst(input logic [9:0] a, input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) exp_rd.push_back(base + 32'(i));
    send_cmd(1'b0, a, 11'(len));
    wait_done("rd_done");
  endtask

  initial begin
    int n, i0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 32'({cmd_ready, wr_ready, rd_valid, busy, done, m_chipselect, m_write, m_clken}), 32'd0);
    chk("reset_m_bus", 32'(m_address) | m_writedata | 32'(m_byteenable), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("clken_on", 32'(m_clken), 32'd1);
    rd_ready = 1'b1;
    wr_burst(10'h010, 4, 32'hA0);
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'hA0 + 32'(i));
    send_cmd(1'b0, 10'h010, 11'd4);
    chk("rd_first_issue", 32'(m_chipselect && !m_write), 32'd1);
    n = 0;
    while (!rd_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_latency", 32'(n), 32'd2);
    wait_done("rd_done");
    wr_burst(10'h3FE, 4, 32'hB0);
    rd_burst(10'h3FE, 4, 32'hB0);
    wr_burst(10'h100, 8, 32'hC0);
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'hC0 + 32'(i));
    i0 = rd_iss;
    send_cmd(1'b0, 10'h100, 11'd8);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_issues", 32'(rd_iss - i0), 32'd4);
    chk("stall_rd_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    wait_done("rd_stall_done");
    chk("rd_all_delivered", 32'(exp_rd.size()), 32'd0);
    i0 = wr_cnt + rd_iss;
    send_cmd(1'b0, 10'h020, 11'd0);
    chk("len0_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_no_access", 32'(wr_cnt + rd_iss - i0), 32'd0);
    chk("wr_total", 32'(wr_cnt), 32'd16);
    chk("done_total", 32'(done_cnt), 32'd7);
    chk("wr_all_seen", 32'(exp_wr.size()), 32'd0);
    rd_ready = 1'b0;
    send_cmd(1'b0, 10'h100, 11'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_rd_valid", 32'(rd_valid), 32'd1);
    i0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_flags", 32'({rd_valid, busy, cmd_ready}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - i0), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
